// File: rtl/dds_pkg.sv
// Shared DDS definitions: load-state encoding and default datapath widths,
// common to the mealy controller and the sample reader.
package dds_pkg;
   localparam int DDS_DATA_W = 8;
   localparam int DDS_ADDR_W = 4;
   localparam int DDS_ACC_W  = 8;

   typedef enum logic [1:0] {
      ST_EMPTY   = 2'd0,
      ST_LOADING = 2'd1,
      ST_FULL    = 2'd2
   } load_state_e;
endpackage

// File: rtl/dds_sample_reader_if.sv
// Controller <-> sample reader bus; the controller is the master, the reader
// is the slave that returns ram_full and the output sample stream.
interface dds_sample_reader_if #(
   parameter int DATA_W = 8,
   parameter int ADDR_W = 4
);
   logic              clear_ram;
   logic              write_ena;
   logic              tuning_ena;
   logic              phase_ena;
   logic [DATA_W-1:0] data_in;
   logic              ram_full;
   logic [ADDR_W:0]   fill_count;
   logic              overrun;
   logic [DATA_W-1:0] sample_out;
   logic              sample_valid;

   modport master (
      output clear_ram, write_ena, tuning_ena, phase_ena, data_in,
      input  ram_full, fill_count, overrun, sample_out, sample_valid
   );
   modport slave (
      input  clear_ram, write_ena, tuning_ena, phase_ena, data_in,
      output ram_full, fill_count, overrun, sample_out, sample_valid
   );
endinterface

// File: rtl/dds_sample_ram.sv
// Simple dual-port sample memory: synchronous write, registered read.
// Contents are intentionally not reset.
module dds_sample_ram #(
   parameter int DATA_W = 8,
   parameter int ADDR_W = 4
) (
   input  logic              clk,
   input  logic              wr_en,
   input  logic [ADDR_W-1:0] wr_addr,
   input  logic [DATA_W-1:0] wr_data,
   input  logic              rd_en,
   input  logic [ADDR_W-1:0] rd_addr,
   output logic [DATA_W-1:0] rd_data
);
   localparam int DEPTH = 1 << ADDR_W;

   logic [DATA_W-1:0] mem [DEPTH];
   logic [DATA_W-1:0] rd_data_q;

   always_ff @(posedge clk) begin
      if (wr_en) mem[wr_addr] <= wr_data;
      if (rd_en) rd_data_q <= mem[rd_addr];
   end

   assign rd_data = rd_data_q;
endmodule

// File: rtl/dds_sample_reader.sv
// DDS sample reader: loads the sample RAM, latches the tuning word and runs the
// phase accumulator, streaming RAM samples with a 2-cycle read latency.
module dds_sample_reader
   import dds_pkg::*;
#(
   parameter int                DATA_W = DDS_DATA_W,
   parameter int                ADDR_W = DDS_ADDR_W,
   parameter int                ACC_W  = DDS_ACC_W,
   parameter logic [ACC_W-1:0]  TW_RST = ACC_W'(1)
) (
   input  logic                clk,
   input  logic                reset,
   dds_sample_reader_if.slave  bus
);
   localparam int DEPTH = 1 << ADDR_W;

   load_state_e       state_q, state_d;
   logic [ADDR_W:0]   fill_q, fill_d;
   logic [ACC_W-1:0]  acc_q, acc_d;
   logic [ACC_W-1:0]  tw_q, tw_d;
   logic              overrun_q, overrun_d;
   logic [DATA_W-1:0] sample_out_q, sample_out_d;
   // [0]: RAM read data valid, [1]: output register valid
   logic [1:0]        vld_pipe_q, vld_pipe_d;

   logic              smp_wr, tw_ld, step, ram_we;
   logic [DATA_W-1:0] rd_data;

   always_comb begin
      smp_wr       = bus.write_ena & ~bus.tuning_ena;
      tw_ld        = bus.write_ena &  bus.tuning_ena;
      step         = bus.phase_ena & (state_q == ST_FULL) & ~bus.clear_ram;
      state_d      = state_q;
      fill_d       = fill_q;
      acc_d        = acc_q;
      tw_d         = tw_q;
      overrun_d    = 1'b0;
      ram_we       = 1'b0;
      vld_pipe_d   = {vld_pipe_q[0], step};
      sample_out_d = sample_out_q;

      // Step reads with the old tuning word even if a new one loads this cycle
      if (tw_ld) tw_d = ACC_W'(bus.data_in);
      if (step)  acc_d = acc_q + tw_q;

      if (bus.clear_ram) begin
         state_d    = ST_EMPTY;
         fill_d     = '0;
         acc_d      = '0;
         vld_pipe_d = '0;
      end else begin
         if (vld_pipe_q[0]) sample_out_d = rd_data;
         if (smp_wr) begin
            case (state_q)
               ST_EMPTY: begin
                  ram_we  = 1'b1;
                  fill_d  = (ADDR_W+1)'(1);
                  state_d = ST_LOADING;
               end
               ST_LOADING: begin
                  ram_we = 1'b1;
                  fill_d = fill_q + (ADDR_W+1)'(1);
                  if (fill_q == (ADDR_W+1)'(DEPTH-1)) state_d = ST_FULL;
               end
               default: overrun_d = 1'b1;
            endcase
         end
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q      <= ST_EMPTY;
         fill_q       <= '0;
         acc_q        <= '0;
         tw_q         <= TW_RST;
         overrun_q    <= 1'b0;
         sample_out_q <= '0;
         vld_pipe_q   <= '0;
      end else begin
         state_q      <= state_d;
         fill_q       <= fill_d;
         acc_q        <= acc_d;
         tw_q         <= tw_d;
         overrun_q    <= overrun_d;
         sample_out_q <= sample_out_d;
         vld_pipe_q   <= vld_pipe_d;
      end
   end

   dds_sample_ram #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) u_ram (
      .clk     (clk),
      .wr_en   (ram_we & ~reset),
      .wr_addr (fill_q[ADDR_W-1:0]),
      .wr_data (bus.data_in),
      .rd_en   (step & ~reset),
      .rd_addr (acc_q[ACC_W-1 -: ADDR_W]),
      .rd_data (rd_data)
   );

   assign bus.ram_full     = (state_q == ST_FULL);
   assign bus.fill_count   = fill_q;
   assign bus.overrun      = overrun_q;
   assign bus.sample_out   = sample_out_q;
   assign bus.sample_valid = vld_pipe_q[1];
endmodule
